// File: rtl/pipeline_hazard_ctl.sv
// Hazard controller for a five-stage pipeline: load-use stall, taken-branch flush,
// EX/MEM and MEM/WB operand forwarding, plus saturating stall/flush counters.
//
// state    | meaning
// RUN      | previous cycle had no hazard
// LU_HOLD  | previous cycle stalled on a load-use hazard
// BR_FLUSH | previous cycle flushed for a taken branch
module pipeline_hazard_ctl (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic [4:0]  idex_rs,
    input  logic [4:0]  idex_rt,
    input  logic        idex_memread,
    input  logic        exmem_branch,
    input  logic        exmem_zero,
    input  logic        exmem_regwrite,
    input  logic [4:0]  exmem_rd,
    input  logic        memwb_regwrite,
    input  logic [4:0]  memwb_rd,
    output logic        pc_write,
    output logic        ifid_write,
    output logic        idex_bubble,
    output logic        flush_ifid,
    output logic        flush_idex,
    output logic        flush_exmem,
    output logic        pc_src,
    output logic [1:0]  forward_a,
    output logic [1:0]  forward_b,
    output logic [1:0]  state,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt
);

    localparam logic [1:0] RUN      = 2'b00;
    localparam logic [1:0] LU_HOLD  = 2'b01;
    localparam logic [1:0] BR_FLUSH = 2'b10;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b10;
    localparam logic [1:0] FWD_MEMWB = 2'b01;

    logic       lu;
    logic       bt;
    logic [1:0] state_d;

    assign lu = idex_memread && (idex_rt != 5'd0) &&
                ((idex_rt == id_rs) || (idex_rt == id_rt));
    assign bt = exmem_branch && exmem_zero;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            stall_cnt <= 16'd0;
            flush_cnt <= 16'd0;
        end else begin
            state <= state_d;
            if (bt && (flush_cnt != 16'hFFFF))
                flush_cnt <= flush_cnt + 16'd1;
            if (lu && !bt && (stall_cnt != 16'hFFFF))
                stall_cnt <= stall_cnt + 16'd1;
        end
    end

    // Hold and flush states last one cycle; every cycle re-evaluates the hazards.
    always_comb begin
        state_d = RUN;
        if (bt)
            state_d = BR_FLUSH;
        else if (lu)
            state_d = LU_HOLD;
    end

    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        idex_bubble = 1'b0;
        flush_ifid  = 1'b0;
        flush_idex  = 1'b0;
        flush_exmem = 1'b0;
        pc_src      = 1'b0;
        if (!rst) begin
            if (bt) begin
                pc_src      = 1'b1;
                flush_ifid  = 1'b1;
                flush_idex  = 1'b1;
                flush_exmem = 1'b1;
            end else if (lu) begin
                pc_write    = 1'b0;
                ifid_write  = 1'b0;
                idex_bubble = 1'b1;
            end
        end
    end

    // EX/MEM is the younger result, so it wins over MEM/WB.
    always_comb begin
        forward_a = FWD_RF;
        forward_b = FWD_RF;
        if (!rst) begin
            if (exmem_regwrite && (exmem_rd != 5'd0) && (exmem_rd == idex_rs))
                forward_a = FWD_EXMEM;
            else if (memwb_regwrite && (memwb_rd != 5'd0) && (memwb_rd == idex_rs))
                forward_a = FWD_MEMWB;
            if (exmem_regwrite && (exmem_rd != 5'd0) && (exmem_rd == idex_rt))
                forward_b = FWD_EXMEM;
            else if (memwb_regwrite && (memwb_rd != 5'd0) && (memwb_rd == idex_rt))
                forward_b = FWD_MEMWB;
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctl.sv
// Self-checking bench for pipeline_hazard_ctl: hand-computed vector table,
// directed multi-cycle sequences and randomized traffic against a reference model.
module tb_pipeline_hazard_ctl;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs, id_rt, idex_rs, idex_rt, exmem_rd, memwb_rd;
    logic        idex_memread, exmem_branch, exmem_zero, exmem_regwrite, memwb_regwrite;
    logic        pc_write, ifid_write, idex_bubble, flush_ifid, flush_idex, flush_exmem, pc_src;
    logic [1:0]  forward_a, forward_b, state;
    logic [15:0] stall_cnt, flush_cnt;

    int checks = 0;
    int errors = 0;
    int m_state = 0;
    int m_stall = 0;
    int m_flush = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctl dut (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt), .idex_rs(idex_rs), .idex_rt(idex_rt),
        .idex_memread(idex_memread), .exmem_branch(exmem_branch), .exmem_zero(exmem_zero),
        .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd),
        .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd),
        .pc_write(pc_write), .ifid_write(ifid_write), .idex_bubble(idex_bubble),
        .flush_ifid(flush_ifid), .flush_idex(flush_idex), .flush_exmem(flush_exmem),
        .pc_src(pc_src), .forward_a(forward_a), .forward_b(forward_b),
        .state(state), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    typedef struct {
        int rs, rt, ers, ert, mr, br, z, erw, erd, mrw, mrd;
        int pw, iw, bub, fl, ps, fa, fb, nst;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic bit m_lu();
        return idex_memread && idex_rt != 0 && (idex_rt == id_rs || idex_rt == id_rt);
    endfunction

    function automatic bit m_bt();
        return exmem_branch && exmem_zero;
    endfunction

    // Forward code as a number: 2 = EX/MEM, 1 = MEM/WB, 0 = register file.
    function automatic int m_fwd(input int src);
        if (rst) return 0;
        if (exmem_regwrite && exmem_rd != 0 && int'(exmem_rd) == src) return 2;
        if (memwb_regwrite && memwb_rd != 0 && int'(memwb_rd) == src) return 1;
        return 0;
    endfunction

    task automatic check_comb(input string tag);
        bit stall, flush;
        #1;
        flush = !rst && m_bt();
        stall = !rst && !m_bt() && m_lu();
        chk({tag, "_pc_write"},   int'(pc_write),    stall ? 0 : 1);
        chk({tag, "_ifid_write"}, int'(ifid_write),  stall ? 0 : 1);
        chk({tag, "_bubble"},     int'(idex_bubble), int'(stall));
        chk({tag, "_flush"},      int'({flush_ifid, flush_idex, flush_exmem}), flush ? 7 : 0);
        chk({tag, "_pc_src"},     int'(pc_src),      int'(flush));
        chk({tag, "_fwd_a"},      int'(forward_a),   m_fwd(int'(idex_rs)));
        chk({tag, "_fwd_b"},      int'(forward_b),   m_fwd(int'(idex_rt)));
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) begin
            m_state = 0; m_stall = 0; m_flush = 0;
        end else if (m_bt()) begin
            m_state = 2;
            if (m_flush < 65535) m_flush++;
        end else if (m_lu()) begin
            m_state = 1;
            if (m_stall < 65535) m_stall++;
        end else begin
            m_state = 0;
        end
        #1;
    endtask

    task automatic check_seq(input string tag);
        chk({tag, "_state"}, int'(state),     m_state);
        chk({tag, "_stall"}, int'(stall_cnt), m_stall);
        chk({tag, "_flushc"}, int'(flush_cnt), m_flush);
    endtask

    task automatic step(input string tag);
        check_comb(tag);
        tick();
        check_seq(tag);
    endtask

    task automatic idle_inputs();
        id_rs = 0; id_rt = 0; idex_rs = 0; idex_rt = 0; exmem_rd = 0; memwb_rd = 0;
        idex_memread = 0; exmem_branch = 0; exmem_zero = 0;
        exmem_regwrite = 0; memwb_regwrite = 0;
    endtask

    task automatic apply_vec(input vec_t v);
        id_rs = 5'(v.rs); id_rt = 5'(v.rt); idex_rs = 5'(v.ers); idex_rt = 5'(v.ert);
        idex_memread = 1'(v.mr); exmem_branch = 1'(v.br); exmem_zero = 1'(v.z);
        exmem_regwrite = 1'(v.erw); exmem_rd = 5'(v.erd);
        memwb_regwrite = 1'(v.mrw); memwb_rd = 5'(v.mrd);
    endtask

    initial begin
        //            rs rt ers ert mr br z erw erd mrw mrd | pw iw bub fl ps fa fb nst
        vecs[0]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 0, 0, 0, 0};
        vecs[1]  = '{8, 0, 0, 8, 1, 0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 0, 0, 0, 1};
        vecs[2]  = '{3, 9, 0, 9, 1, 0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 0, 0, 0, 1};
        vecs[3]  = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 0, 0, 0, 0};
        vecs[4]  = '{0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0,  1, 1, 0, 1, 1, 0, 0, 2};
        vecs[5]  = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0,  1, 1, 0, 0, 0, 0, 0, 0};
        vecs[6]  = '{8, 0, 0, 8, 1, 1, 1, 0, 0, 0, 0,  1, 1, 0, 1, 1, 0, 0, 2};
        vecs[7]  = '{0, 0, 5, 0, 0, 0, 0, 1, 5, 1, 5,  1, 1, 0, 0, 0, 2, 0, 0};
        vecs[8]  = '{0, 0, 5, 0, 0, 0, 0, 1, 0, 1, 5,  1, 1, 0, 0, 0, 1, 0, 0};
        vecs[9]  = '{0, 0, 0, 7, 0, 0, 0, 1, 7, 1, 7,  1, 1, 0, 0, 0, 0, 2, 0};
        vecs[10] = '{0, 0, 0, 6, 0, 0, 0, 1, 4, 1, 6,  1, 1, 0, 0, 0, 0, 1, 0};
        vecs[11] = '{0, 0, 5, 0, 0, 0, 0, 0, 0, 0, 5,  1, 1, 0, 0, 0, 0, 0, 0};

        // Reset with live hazards and forwards on the inputs: all outputs forced quiet.
        idle_inputs();
        rst = 1;
        id_rs = 8; idex_rt = 8; idex_memread = 1; exmem_branch = 1; exmem_zero = 1;
        idex_rs = 5; exmem_regwrite = 1; exmem_rd = 5;
        step("rst0");
        step("rst1");
        chk("rst_state_const", int'(state), 0);
        chk("rst_stall_const", int'(stall_cnt), 0);

        rst = 0;
        idle_inputs();
        foreach (vecs[i]) begin
            apply_vec(vecs[i]);
            #1;
            chk($sformatf("v%0d_pw", i),  int'(pc_write),    vecs[i].pw);
            chk($sformatf("v%0d_iw", i),  int'(ifid_write),  vecs[i].iw);
            chk($sformatf("v%0d_bub", i), int'(idex_bubble), vecs[i].bub);
            chk($sformatf("v%0d_fl", i),  int'({flush_ifid, flush_idex, flush_exmem}), vecs[i].fl * 7);
            chk($sformatf("v%0d_ps", i),  int'(pc_src),      vecs[i].ps);
            chk($sformatf("v%0d_fa", i),  int'(forward_a),   vecs[i].fa);
            chk($sformatf("v%0d_fb", i),  int'(forward_b),   vecs[i].fb);
            step($sformatf("v%0d", i));
            chk($sformatf("v%0d_nst", i), int'(state), vecs[i].nst);
        end

        // Load-use from a clean reset: stall_cnt 0 -> 1, then back-to-back holds.
        rst = 1; idle_inputs(); step("lu_rst");
        rst = 0; id_rs = 8; idex_rt = 8; idex_memread = 1;
        step("lu1");
        chk("lu1_state_const", int'(state), 1);
        chk("lu1_stall_const", int'(stall_cnt), 1);
        step("lu2");
        chk("lu2_stall_const", int'(stall_cnt), 2);

        // Branch taken then reset during BR_FLUSH.
        idle_inputs(); exmem_branch = 1; exmem_zero = 1;
        step("bt1");
        chk("bt1_state_const", int'(state), 2);
        chk("bt1_flush_const", int'(flush_cnt), 1);
        rst = 1;
        step("bt_rst");
        chk("bt_rst_state_const", int'(state), 0);
        chk("bt_rst_flush_const", int'(flush_cnt), 0);
        rst = 0; idle_inputs();
        step("after_rst");

        // Reset during LU_HOLD.
        id_rs = 4; idex_rt = 4; idex_memread = 1;
        step("luh");
        rst = 1; step("luh_rst");
        rst = 0; idle_inputs(); step("luh_after");

        // Randomized traffic; small register range to hit matches often.
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 60) == 0);
            id_rs = 5'($urandom_range(0, 3)); id_rt = 5'($urandom_range(0, 3));
            idex_rs = 5'($urandom_range(0, 3)); idex_rt = 5'($urandom_range(0, 3));
            exmem_rd = 5'($urandom_range(0, 3)); memwb_rd = 5'($urandom_range(0, 3));
            idex_memread = 1'($urandom); exmem_branch = 1'($urandom);
            exmem_zero = 1'($urandom); exmem_regwrite = 1'($urandom);
            memwb_regwrite = 1'($urandom);
            step("rnd");
        end

        // Saturation: 65534 load-use cycles, then three more must stick at 16'hFFFF.
        rst = 1; idle_inputs(); step("sat_rst");
        rst = 0; id_rt = 8; idex_rt = 8; idex_memread = 1;
        for (int n = 0; n < 65534; n++) tick();
        chk("sat_pre", int'(stall_cnt), 65534);
        for (int n = 0; n < 3; n++) begin
            step("sat");
            chk($sformatf("sat_hold%0d", n), int'(stall_cnt), 65535);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
